// File: rtl/alu181_nibble_sequencer.sv
// alu181_nibble_sequencer
//   Runs WIDTH-bit ALU operations on one external combinational 74181-style slice, one
//   nibble per clock, LSB nibble first. The active-low carry ripples between passes and
//   the result, final carry-out and A=B flag are assembled for a valid/ready consumer.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           request handshake
//   in_a, in_b                  WIDTH-bit operands
//   in_s, in_m, in_cnb          function select, mode (1 = logic), active-low carry-in
//   alu_a/b/s/m/cnb             drive to the slice
//   alu_f, alu_cn4b, alu_aeb    slice result, active-low carry-out, A=B
//   out_valid/out_ready         result handshake
//   out_f, out_cn4b, out_aeb    assembled result, final carry-out, AND of slice aeb
//   busy                        operation in progress or result pending
module alu181_nibble_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_s,
   input  logic             in_m,
   input  logic             in_cnb,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cnb,
   input  logic [3:0]       alu_f,
   input  logic             alu_cn4b,
   input  logic             alu_aeb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             out_cn4b,
   output logic             out_aeb,
   output logic             busy
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_s;
   logic             r_m;
   logic             r_carry;
   logic             r_aeb_acc;
   logic [IdxW-1:0]  r_idx;
   logic [WIDTH-1:0] r_f_work;
   logic [WIDTH-1:0] r_out_f;
   logic             r_out_cn4b;
   logic             r_out_aeb;

   logic             w_last;
   logic [WIDTH-1:0] w_nib_mask;
   logic [WIDTH-1:0] w_f_merged;

   assign w_last     = (r_idx == LastIdx);
   assign w_nib_mask = WIDTH'(4'hF) << {r_idx, 2'b00};
   // Working result with the current slice nibble inserted; on the last pass this is the
   // complete result, so the output register can load it in the same edge.
   assign w_f_merged = (r_f_work & ~w_nib_mask) | ((WIDTH'(alu_f) << {r_idx, 2'b00}) & w_nib_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      alu_a        = 4'h0;
      alu_b        = 4'h0;
      alu_cnb      = 1'b1;
      alu_s        = r_s;
      alu_m        = r_m;
      unique case (r_state)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = StRun;
         end
         StRun: begin
            busy    = 1'b1;
            alu_a   = 4'(r_a >> {r_idx, 2'b00});
            alu_b   = 4'(r_b >> {r_idx, 2'b00});
            alu_cnb = r_carry;
            if (w_last) w_state_next = StDone;
         end
         StDone: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_s        <= 4'h0;
         r_m        <= 1'b0;
         r_carry    <= 1'b1;
         r_aeb_acc  <= 1'b1;
         r_idx      <= '0;
         r_f_work   <= '0;
         r_out_f    <= '0;
         r_out_cn4b <= 1'b1;
         r_out_aeb  <= 1'b0;
      end else begin
         if (r_state == StIdle && in_valid) begin
            r_a       <= in_a;
            r_b       <= in_b;
            r_s       <= in_s;
            r_m       <= in_m;
            r_carry   <= in_cnb;
            r_aeb_acc <= 1'b1;
            r_idx     <= '0;
         end else if (r_state == StRun) begin
            r_f_work  <= w_f_merged;
            r_carry   <= alu_cn4b;
            r_aeb_acc <= r_aeb_acc & alu_aeb;
            if (w_last) begin
               // idx is left at the last nibble; it is reloaded on the next accept.
               r_out_f    <= w_f_merged;
               r_out_cn4b <= alu_cn4b;
               r_out_aeb  <= r_aeb_acc & alu_aeb;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign out_f    = r_out_f;
   assign out_cn4b = r_out_cn4b;
   assign out_aeb  = r_out_aeb;

endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// Bench for alu181_nibble_sequencer: combinational 74181 slice model, a scoreboard of
// full-width expected results checked at each result handshake, and directed scenarios.
module tb_alu181_nibble_sequencer;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NIBBLES = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       in_s;
   logic             in_m;
   logic             in_cnb;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_s;
   logic             alu_m;
   logic             alu_cnb;
   logic [3:0]       alu_f;
   logic             alu_cn4b;
   logic             alu_aeb;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_f;
   logic             out_cn4b;
   logic             out_aeb;
   logic             busy;

   typedef struct packed {
      logic [WIDTH-1:0] f;
      logic             cn4b;
      logic             aeb;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu181_nibble_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cnb(in_cnb),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
      .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_cn4b(out_cn4b), .out_aeb(out_aeb), .busy(busy)
   );

   always #5 clk = ~clk;

   // 74181, active-high data: X/Y are the two internal operand terms.
   function automatic logic [5:0] slice181(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] s, input logic m,
                                           input logic cnb);
      logic [3:0] x, y, f;
      logic [4:0] sum;
      x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
      y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
      sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cnb};
      f   = m ? ~(x ^ y) : sum[3:0];
      return {f, ~sum[4], &f};
   endfunction

   always_comb {alu_f, alu_cn4b, alu_aeb} = slice181(alu_a, alu_b, alu_s, alu_m, alu_cnb);

   // Whole-width reference: chained 74181 carries equal one wide addition.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [3:0] s, input logic m, input logic cnb);
      logic [WIDTH-1:0] x, y;
      logic [WIDTH:0]   sum;
      exp_t             e;
      x      = a | (b & {WIDTH{s[0]}}) | (~b & {WIDTH{s[1]}});
      y      = (a & ~b & {WIDTH{s[2]}}) | (a & b & {WIDTH{s[3]}});
      sum    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ~cnb};
      e.f    = m ? ~(x ^ y) : sum[WIDTH-1:0];
      e.cn4b = ~sum[WIDTH];
      e.aeb  = &e.f;
      return e;
   endfunction

   // Result monitor: compare every handshake against the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && out_ready && !rst) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got f=%h cn4b=%b aeb=%b, want no result",
                     out_f, out_cn4b, out_aeb);
         end else begin
            e = sb.pop_front();
            if ({out_f, out_cn4b, out_aeb} !== {e.f, e.cn4b, e.aeb}) begin
               errors++;
               $display("FAIL scoreboard_result: got f=%h cn4b=%b aeb=%b, want f=%h cn4b=%b aeb=%b",
                        out_f, out_cn4b, out_aeb, e.f, e.cn4b, e.aeb);
            end
         end
      end
   end

   // Returns #1 after the accept edge (RUN, idx 0).
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [3:0] s, input logic m, input logic cnb);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: got in_ready=0, want 1 within 20 cycles");
      end
      in_valid = 1'b1;
      in_a = a; in_b = b; in_s = s; in_m = m; in_cnb = cnb;
      sb.push_back(model(a, b, s, m, cnb));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL out_valid_timeout: got out_valid=0, want 1 within 40 cycles");
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_handshake: got ready/valid/busy=%b, want 100",
                  {in_ready, out_valid, busy});
      end
      checks++;
      if ({out_f, out_cn4b, out_aeb} !== {{WIDTH{1'b0}}, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got f=%h cn4b=%b aeb=%b, want f=0 cn4b=1 aeb=0",
                  out_f, out_cn4b, out_aeb);
      end
      checks++;
      if ({alu_a, alu_b, alu_s, alu_m, alu_cnb} !== 14'b00000000000001) begin
         errors++;
         $display("FAIL reset_slice_drive: got a=%h b=%h s=%h m=%b cnb=%b, want 0 0 0 0 1",
                  alu_a, alu_b, alu_s, alu_m, alu_cnb);
      end
   endtask

   task automatic test_add();
      int cyc;
      start_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
      checks++;
      if ({alu_a, alu_b, alu_s, alu_m, alu_cnb} !== {4'hF, 4'h1, 4'b1001, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_slice_drive: got a=%h b=%h s=%h m=%b cnb=%b, want F 1 9 0 1",
                  alu_a, alu_b, alu_s, alu_m, alu_cnb);
      end
      checks++;
      if ({in_ready, busy} !== 2'b01) begin
         errors++;
         $display("FAIL add_run_flags: got ready/busy=%b, want 01", {in_ready, busy});
      end
      wait_valid(cyc);
      checks++;
      if (cyc != NIBBLES) begin
         errors++;
         $display("FAIL add_latency: got %0d cycles, want %0d", cyc, NIBBLES);
      end
      checks++;
      if ({out_f, out_cn4b} !== {16'h0100, 1'b1}) begin
         errors++;
         $display("FAIL add_result: got f=%h cn4b=%b, want f=0100 cn4b=1", out_f, out_cn4b);
      end
      take_result();
      checks++;
      if ({in_ready, out_valid, busy, out_f} !== {3'b100, 16'h0100}) begin
         errors++;
         $display("FAIL add_idle_hold: got rvb=%b f=%h, want rvb=100 f=0100",
                  {in_ready, out_valid, busy}, out_f);
      end
      start_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
      wait_valid(cyc);
      checks++;
      if ({out_f, out_cn4b} !== {16'h0000, 1'b0}) begin
         errors++;
         $display("FAIL add_overflow: got f=%h cn4b=%b, want f=0000 cn4b=0", out_f, out_cn4b);
      end
      take_result();
   endtask

   task automatic test_sub();
      int cyc;
      start_op(16'h1234, 16'h0234, 4'b0110, 1'b0, 1'b0);
      wait_valid(cyc);
      checks++;
      if ({out_f, out_cn4b} !== {16'h1000, 1'b0}) begin
         errors++;
         $display("FAIL sub_result: got f=%h cn4b=%b, want f=1000 cn4b=0", out_f, out_cn4b);
      end
      take_result();
      start_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1);
      wait_valid(cyc);
      checks++;
      if ({out_f, out_aeb} !== {16'hFFFF, 1'b1}) begin
         errors++;
         $display("FAIL sub_equal: got f=%h aeb=%b, want f=FFFF aeb=1", out_f, out_aeb);
      end
      take_result();
   endtask

   task automatic test_logic();
      int cyc;
      start_op(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1);
      wait_valid(cyc);
      checks++;
      if ({out_f, out_aeb} !== {16'hF000, 1'b0}) begin
         errors++;
         $display("FAIL logic_and: got f=%h aeb=%b, want f=F000 aeb=0", out_f, out_aeb);
      end
      take_result();
   endtask

   task automatic test_backpressure();
      int   cyc;
      exp_t e;
      start_op(16'h0F0F, 16'h1111, 4'b1001, 1'b0, 1'b0);
      e = model(16'h0F0F, 16'h1111, 4'b1001, 1'b0, 1'b0);
      wait_valid(cyc);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a = 16'($urandom); in_b = 16'($urandom); in_s = 4'($urandom); in_cnb = 1'b0;
         checks++;
         if ({out_valid, in_ready, busy, out_f, out_cn4b, out_aeb} !==
             {3'b101, e.f, e.cn4b, e.aeb}) begin
            errors++;
            $display("FAIL backpressure_hold: cycle %0d got vrb=%b f=%h cn4b=%b, want 101 f=%h cn4b=%b",
                     i, {out_valid, in_ready, busy}, out_f, out_cn4b, e.f, e.cn4b);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      take_result();
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL backpressure_release: got ready/busy=%b, want 10", {in_ready, busy});
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      for (int i = 0; i < 8; i++) begin
         start_op(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         wait_valid(cyc);
         checks++;
         if (cyc != NIBBLES) begin
            errors++;
            $display("FAIL b2b_latency: op %0d got %0d cycles, want %0d", i, cyc, NIBBLES);
         end
         take_result();
      end
   endtask

   task automatic test_midrun_reset();
      int cyc;
      start_op(16'h1357, 16'h2468, 4'b1001, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_back());
      checks++;
      if ({in_ready, out_valid, busy, out_f, out_cn4b, out_aeb} !==
          {3'b100, {WIDTH{1'b0}}, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midrun_reset: got rvb=%b f=%h cn4b=%b aeb=%b, want 100 f=0 cn4b=1 aeb=0",
                  {in_ready, out_valid, busy}, out_f, out_cn4b, out_aeb);
      end
      start_op(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1);
      wait_valid(cyc);
      checks++;
      if ({out_f, out_cn4b} !== {16'h0000, 1'b0}) begin
         errors++;
         $display("FAIL after_reset_op: got f=%h cn4b=%b, want f=0000 cn4b=0", out_f, out_cn4b);
      end
      take_result();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_s = 4'h0; in_m = 1'b0; in_cnb = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_backpressure();
      test_back_to_back();
      test_midrun_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, want finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
